// File: rtl/masked_share_gen_pkg.sv
// Shared types and constants for the masked share generator.
// Holds the FSM encoding, LFSR polynomial, default seed and share bundle.
package masked_share_gen_pkg;

    typedef enum logic [1:0] {
        ST_WARM = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    localparam logic [31:0] LFSR_POLY      = 32'h8020_0003;
    localparam logic [31:0] SEED_DEFAULT_C = 32'hACE1_2D5B;

    typedef struct packed {
        logic A0;
        logic A1;
        logic B0;
        logic B1;
        logic rN;
    } share_t;

    // Split A and B into two shares each using independent PRNG bits.
    function automatic share_t mk_share(input logic a, input logic b,
                                        input logic [2:0] mnr);
        share_t s;
        s.A0 = a ^ mnr[0];
        s.A1 = mnr[0];
        s.B0 = b ^ mnr[1];
        s.B1 = mnr[1];
        s.rN = mnr[2];
        return s;
    endfunction

endpackage

// File: rtl/masked_share_gen_lfsr.sv
// Galois LFSR mask source: 3-bit advance per step, reseed and zero-lock.
// A zero state can never advance, so it is replaced by the default seed.
module masked_lfsr
    import masked_share_gen_pkg::*;
#(
    parameter int              W    = 32,
    parameter logic [W-1:0]    SEED = W'(SEED_DEFAULT_C)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] seed_i,
    input  logic         step_i,
    output logic [W-1:0] state_o
);

    logic [W-1:0] state_q;
    logic [W-1:0] state_d;

    function automatic logic [W-1:0] shift1(input logic [W-1:0] s);
        return (s >> 1) ^ (s[0] ? W'(LFSR_POLY) : '0);
    endfunction

    // Next state: reseed beats zero recovery, which beats a step.
    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = (seed_i == '0) ? SEED : seed_i;
        end else if (state_q == '0) begin
            state_d = SEED;
        end else if (step_i) begin
            state_d = shift1(shift1(shift1(state_q)));
        end
    end

    // State register with synchronous reset to the default seed.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= SEED;
        else        state_q <= state_d;
    end

    assign state_o = state_q;

endmodule

// File: rtl/masked_share_gen.sv
// Converts an unmasked operand pair into fresh Boolean shares plus a
// refresh mask for a masked half adder, with warm-up and reseed control.
module masked_share_gen
    import masked_share_gen_pkg::*;
#(
    parameter int                 LFSR_W       = 32,
    parameter int                 WARMUP       = 16,
    parameter logic [LFSR_W-1:0]  SEED_DEFAULT = LFSR_W'(SEED_DEFAULT_C)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_seed_valid,
    input  logic [LFSR_W-1:0] i_seed,
    input  logic              i_valid,
    input  logic              i_A,
    input  logic              i_B,
    output logic              o_ready,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_A0,
    output logic              o_A1,
    output logic              o_B0,
    output logic              o_B1,
    output logic              o_rN,
    output logic [1:0]        o_state
);

    localparam int             CNT_W    = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WARMUP - 1);

    state_e             st_q;
    state_e             st_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               valid_q;
    share_t             share_q;
    logic [LFSR_W-1:0]  lfsr;
    logic               run;
    logic               accept;
    logic               lfsr_step;

    masked_lfsr #(
        .W    (LFSR_W),
        .SEED (SEED_DEFAULT)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (i_seed_valid),
        .seed_i  (i_seed),
        .step_i  (lfsr_step),
        .state_o (lfsr)
    );

    // FSM and warm-up counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q  <= ST_WARM;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

    // Next state: reseed restarts warm-up; otherwise count out WARMUP cycles.
    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        if (i_seed_valid) begin
            st_d  = ST_WARM;
            cnt_d = '0;
        end else begin
            case (st_q)
                ST_RUN: st_d = ST_RUN;
                default: begin
                    st_d = ST_WARM;
                    if (cnt_q == CNT_LAST) begin
                        st_d  = ST_RUN;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // Outputs: handshake and PRNG stepping derived from the current state.
    always_comb begin
        run       = (st_q == ST_RUN);
        o_ready   = run && !i_seed_valid && (!valid_q || i_ready);
        accept    = i_valid && o_ready;
        lfsr_step = !run || accept;
    end

    // Share bundle register: reseed drops it, accept reloads, consume clears.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            share_q <= '0;
        end else if (i_seed_valid) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            share_q <= mk_share(i_A, i_B, lfsr[2:0]);
        end else if (i_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign o_valid = valid_q;
    assign o_A0    = share_q.A0;
    assign o_A1    = share_q.A1;
    assign o_B0    = share_q.B0;
    assign o_B1    = share_q.B1;
    assign o_rN    = share_q.rN;
    assign o_state = st_q;

endmodule

// File: tb/tb_masked_share_gen.sv
// Self-checking bench for masked_share_gen against a behavioural model.
// Model tracks the mask stream, warm-up window and bundle occupancy.
module tb_masked_share_gen;

    localparam logic [31:0] SEED = 32'hACE1_2D5B;
    localparam logic [31:0] POLY = 32'h8020_0003;
    localparam int          WARM = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_seed_valid;
    logic [31:0] i_seed;
    logic        i_valid;
    logic        i_A;
    logic        i_B;
    logic        o_ready;
    logic        o_valid;
    logic        i_ready;
    logic        o_A0, o_A1, o_B0, o_B1, o_rN;
    logic [1:0]  o_state;

    int tests  = 0;
    int failed = 0;

    logic [31:0] mdl;
    int          warm_left;
    bit          run;
    bit          mv;
    bit          seen;
    logic [4:0]  sh;

    masked_share_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_seed_valid (i_seed_valid),
        .i_seed       (i_seed),
        .i_valid      (i_valid),
        .i_A          (i_A),
        .i_B          (i_B),
        .o_ready      (o_ready),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_A0         (o_A0),
        .o_A1         (o_A1),
        .o_B0         (o_B0),
        .o_B1         (o_B1),
        .o_rN         (o_rN),
        .o_state      (o_state)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] adv(input logic [31:0] s);
        logic [31:0] t;
        t = s;
        for (int k = 0; k < 3; k++) begin
            if (t[0]) t = (t >> 1) ^ POLY;
            else      t = t >> 1;
        end
        return t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_restart(input logic [31:0] s);
        mdl       = s;
        warm_left = WARM;
        run       = 1'b0;
        mv        = 1'b0;
    endtask

    task automatic cyc(input bit v, input bit a, input bit b,
                       input bit rdy, output bit acc);
        bit er;
        i_seed_valid = 1'b0;
        i_valid      = v;
        i_A          = a;
        i_B          = b;
        i_ready      = rdy;
        #1;
        er = run && (!mv || rdy);
        chk("ready", 32'(o_ready), 32'(er));
        chk("lfsr", dut.u_lfsr.state_o, mdl);
        chk("state", 32'(o_state), run ? 32'd2 : 32'd1);
        chk("valid", 32'(o_valid), 32'(mv));
        if (mv || !seen)
            chk("shares", 32'({o_A0, o_A1, o_B0, o_B1, o_rN}), 32'(sh));
        acc = v && er;
        if (acc) begin
            sh   = {a ^ mdl[0], mdl[0], b ^ mdl[1], mdl[1], mdl[2]};
            mdl  = adv(mdl);
            mv   = 1'b1;
            seen = 1'b1;
        end else begin
            if (rdy) mv = 1'b0;
            if (!run) begin
                mdl = adv(mdl);
                warm_left--;
                if (warm_left == 0) run = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (acc) begin
            chk("lat_valid", 32'(o_valid), 32'd1);
            chk("recomb_A", 32'(o_A0 ^ o_A1), 32'(a));
            chk("recomb_B", 32'(o_B0 ^ o_B1), 32'(b));
        end
    endtask

    task automatic reseed(input logic [31:0] s);
        i_seed_valid = 1'b1;
        i_seed       = s;
        i_valid      = 1'b1;
        i_ready      = 1'b1;
        #1;
        chk("rs_ready", 32'(o_ready), 32'd0);
        @(posedge clk);
        #1;
        i_seed_valid = 1'b0;
        i_valid      = 1'b0;
        model_restart((s == 32'd0) ? SEED : s);
        chk("rs_valid", 32'(o_valid), 32'd0);
        chk("rs_state", 32'(o_state), 32'd1);
        chk("rs_lfsr", dut.u_lfsr.state_o, mdl);
    endtask

    initial begin
        bit acc;
        int n;

        rst_n        = 1'b0;
        i_seed_valid = 1'b0;
        i_seed       = '0;
        i_valid      = 1'b1;
        i_A          = 1'b1;
        i_B          = 1'b1;
        i_ready      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_shares", 32'({o_A0, o_A1, o_B0, o_B1, o_rN}), 32'd0);
        chk("rst_state", 32'(o_state), 32'd1);
        chk("rst_lfsr", dut.u_lfsr.state_o, SEED);

        rst_n = 1'b1;
        model_restart(SEED);
        seen = 1'b0;
        sh   = '0;
        for (int i = 0; i < WARM + 1; i++)
            cyc(1'b1, 1'($urandom), 1'($urandom), 1'b1, acc);

        n = 0;
        for (int i = 0; i < 5000 && n < 1000; i++) begin
            cyc(($urandom % 4) != 0, 1'($urandom), 1'($urandom), 1'b1, acc);
            if (acc) n++;
        end
        chk("accept_count", 32'(n), 32'd1000);

        cyc(1'b1, 1'($urandom), 1'($urandom), 1'b1, acc);
        for (int i = 0; i < 5; i++)
            cyc(1'b1, 1'($urandom), 1'($urandom), 1'b0, acc);
        for (int i = 0; i < 20; i++)
            cyc(1'b1, 1'($urandom), 1'($urandom), 1'b1, acc);

        reseed(32'd0);
        for (int i = 0; i < WARM + 4; i++)
            cyc(1'b1, 1'($urandom), 1'($urandom), 1'b1, acc);

        cyc(1'b1, 1'($urandom), 1'($urandom), 1'b1, acc);
        reseed(32'h0000_0001);
        for (int i = 0; i < WARM + 80; i++)
            cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), acc);

        cyc(1'b0, 1'b0, 1'b0, 1'b1, acc);
        i_valid = 1'b0;
        i_ready = 1'b1;
        force dut.u_lfsr.state_q = 32'h0;
        #1;
        chk("zl_forced", dut.u_lfsr.state_o, 32'h0);
        chk("zl_next", dut.u_lfsr.state_d, SEED);
        @(posedge clk);
        #1;
        release dut.u_lfsr.state_q;
        @(posedge clk);
        #1;
        chk("zl_restore", dut.u_lfsr.state_o, SEED);
        mdl = SEED;
        for (int i = 0; i < 10; i++)
            cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'b1, acc);

        cyc(1'b1, 1'($urandom), 1'($urandom), 1'b0, acc);
        rst_n   = 1'b0;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", 32'(o_valid), 32'd0);
        chk("mid_rst_shares", 32'({o_A0, o_A1, o_B0, o_B1, o_rN}), 32'd0);
        rst_n = 1'b1;
        model_restart(SEED);
        seen = 1'b0;
        sh   = '0;
        for (int i = 0; i < WARM + 6; i++)
            cyc(1'b1, 1'($urandom), 1'($urandom), 1'b1, acc);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/masked_share_gen.md
MASKED_SHARE_GEN -- requirements
Module: masked_share_gen

Interface
REQ-001 The block SHALL have parameter LFSR_W, default 32, giving the PRNG state width.
REQ-002 The block SHALL have parameter WARMUP, default 16, giving the number of PRNG warm-up cycles after reset or reseed.
REQ-003 The block SHALL have parameter SEED_DEFAULT, default 32'hACE1_2D5B (must be nonzero), giving the PRNG state loaded on reset and substituted for any zero seed.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port i_seed_valid, input, 1 bit: reseed request.
REQ-007 The block SHALL have port i_seed, input, LFSR_W bits: seed value, sampled when i_seed_valid=1.
REQ-008 The block SHALL have port i_valid, input, 1 bit: an unmasked operand pair is offered.
REQ-009 The block SHALL have port i_A, input, 1 bit: unmasked operand A.
REQ-010 The block SHALL have port i_B, input, 1 bit: unmasked operand B.
REQ-011 The block SHALL have port o_ready, output, 1 bit: the block accepts the offered operand pair this cycle.
REQ-012 The block SHALL have port o_valid, output, 1 bit: the share bundle is valid.
REQ-013 The block SHALL have port i_ready, input, 1 bit: the downstream masked half-adder stage consumes the bundle.
REQ-014 The block SHALL have ports o_A0, o_A1, o_B0, o_B1, o_rN, output, 1 bit each: registered shares and fresh mask driving the half adder's A0/A1/B0/B1/rN inputs.
REQ-015 The block SHALL have port o_state, output, 2 bits: current FSM state, for debug.

Function
REQ-016 The PRNG SHALL be a Galois LFSR of width LFSR_W with polynomial x^32+x^22+x^2+x+1 (mask 32'h8020_0003).
REQ-017 One PRNG "step" SHALL be a 3-bit advance, implemented as three unrolled single-bit shifts within one cycle.
REQ-018 The FSM SHALL have states WARM=2'd1 and RUN=2'd2; encodings 0 and 3 SHALL be unreachable, and decode to WARM.
REQ-019 In WARM the PRNG SHALL step every cycle, and a warm-up counter SHALL count 0..WARMUP-1.
REQ-020 On the cycle the warm-up counter reaches WARMUP-1, the FSM SHALL go WARM -> RUN.
REQ-021 o_ready SHALL equal (state==RUN) && !i_seed_valid && (!o_valid || i_ready), purely combinationally.
REQ-022 An accept SHALL be the cycle in which i_valid && o_ready.
REQ-023 On accept, with current PRNG bits m=lfsr[0], n=lfsr[1], r=lfsr[2], the output registers SHALL load o_A0=i_A^m, o_A1=m, o_B0=i_B^n, o_B1=n, o_rN=r, and o_valid=1.
REQ-024 On accept the PRNG SHALL step once, so masks are never reused across transactions.
REQ-025 In RUN the PRNG SHALL step only on accept.
REQ-026 When o_valid && !i_ready, the shares SHALL hold stable.
REQ-027 When o_valid && i_ready && no accept, o_valid SHALL clear next cycle.
REQ-028 When a consume and an accept occur in the same cycle, the new bundle SHALL load with no bubble, giving throughput of 1 per cycle.
REQ-029 Latency from accept to o_valid SHALL be 1 cycle.
REQ-030 i_seed_valid SHALL be honoured in any state, with priority over an accept.
REQ-031 On reseed the PRNG SHALL load i_seed, or SEED_DEFAULT if i_seed==0; o_valid SHALL clear; the warm-up counter SHALL clear; and the FSM SHALL enter WARM.
REQ-032 A pending unconsumed bundle SHALL be discarded on reseed.
REQ-033 If the PRNG state ever equals 0, it SHALL reload SEED_DEFAULT on the next cycle.
REQ-034 Shares SHALL never combine i_A with i_B, and no unmasked value SHALL reach any output.

Reset
REQ-035 While rst_n=0 at the clock edge: LFSR=SEED_DEFAULT, state=WARM, warm-up counter=0, o_valid=0, and o_A0=o_A1=o_B0=o_B1=o_rN=0.
REQ-036 o_ready SHALL be 0 during and after reset until RUN is reached.
REQ-037 A reset asserted mid-transaction SHALL drop the bundle with no partial output.

Structure
REQ-038 A shared package SHALL hold the state enum, the LFSR polynomial mask, SEED_DEFAULT and the share-bundle struct {A0,A1,B0,B1,rN}.
REQ-039 The PRNG SHALL be a sub-module masked_lfsr (inputs: load, seed, step; output: state), with the zero-lock guard inside it.
REQ-040 The FSM and output register SHALL be in the top level.

Verification
REQ-041 The bench SHALL check reset: release rst_n, hold i_valid=1 -> o_ready=0 for exactly 16 cycles, o_ready=1 on the 17th, and all outputs 0 until the first accept.
REQ-042 The bench SHALL check recombination: 1000 random accepts with i_ready=1 -> every bundle has o_A0^o_A1==i_A and o_B0^o_B1==i_B, and o_valid appears 1 cycle after each accept.
REQ-043 The bench SHALL check mask sequencing: seed 32'h0000_0001, after warm-up -> the (m,n,r) sequence matches the reference LFSR model step for step, with no step on idle cycles.
REQ-044 The bench SHALL check backpressure: i_ready=0 for 5 cycles with o_valid=1 -> outputs stable and o_ready=0; i_ready=1 with i_valid=1 -> back-to-back accepts, no bubble.
REQ-045 The bench SHALL check reseed: i_seed_valid=1, i_seed=0 while o_valid=1 -> next cycle o_valid=0, LFSR=SEED_DEFAULT, state=WARM, and 16 cycles of o_ready=0.
REQ-046 The bench SHALL check zero-lock: force the LFSR state to 0 -> SEED_DEFAULT is restored the next cycle.
